// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mixer
//  Description : N-channel stereo mixer. All sources are snapshotted on a
//                next_sample strobe and scaled by a 4-bit volume (gain
//                vol/8). The scaled sources are accumulated one channel per
//                clock. The sum is then divided by 8, saturated to IN_W bits
//                and left-justified into OUT_W bits for the DAC interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_sample,
  input  logic [NUM_CH*IN_W-1:0]   ch_left,
  input  logic [NUM_CH*IN_W-1:0]   ch_right,
  input  logic [NUM_CH*4-1:0]      ch_volume,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic                     overrun_clr,
  output logic [OUT_W-1:0]         left_out,
  output logic [OUT_W-1:0]         right_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PROD_W = IN_W + 5;
  localparam int ACC_W  = IN_W + 5 + $clog2(NUM_CH + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [IDX_W-1:0]        c_LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] c_SAT_MAX  = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_SAT_MIN  = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUM_CH*IN_W-1:0]     r_snap_l;
  logic [NUM_CH*IN_W-1:0]     r_snap_r;
  logic [NUM_CH*4-1:0]        r_snap_v;
  logic [NUM_CH-1:0]          r_snap_m;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc_l;
  logic signed [ACC_W-1:0]    r_acc_r;
  logic [OUT_W-1:0]           r_left;
  logic [OUT_W-1:0]           r_right;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_overrun;

  logic signed [IN_W-1:0]     w_smp_l;
  logic signed [IN_W-1:0]     w_smp_r;
  logic [3:0]                 w_vol;
  logic                       w_mute;
  logic signed [4:0]          w_gain;
  logic signed [PROD_W-1:0]   w_prod_l;
  logic signed [PROD_W-1:0]   w_prod_r;
  logic signed [ACC_W-1:0]    w_term_l;
  logic signed [ACC_W-1:0]    w_term_r;
  logic signed [ACC_W-1:0]    w_mix_l;
  logic signed [ACC_W-1:0]    w_mix_r;
  logic [IN_W-1:0]            w_sat_l;
  logic [IN_W-1:0]            w_sat_r;
  logic [OUT_W-1:0]           w_out_l;
  logic [OUT_W-1:0]           w_out_r;

  // Clamp a divided accumulator value to the signed IN_W range
  function automatic logic [IN_W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
    logic [IN_W-1:0] res;
    if (v > c_SAT_MAX) begin
      res = {1'b0, {(IN_W-1){1'b1}}};
    end else if (v < c_SAT_MIN) begin
      res = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      res = v[IN_W-1:0];
    end
    return res;
  endfunction

  // Current channel selected from the snapshot; volume is unsigned so gain gets a zero sign bit
  assign w_smp_l  = r_snap_l[r_idx*IN_W +: IN_W];
  assign w_smp_r  = r_snap_r[r_idx*IN_W +: IN_W];
  assign w_vol    = r_snap_v[r_idx*4 +: 4];
  assign w_mute   = r_snap_m[r_idx];
  assign w_gain   = $signed({1'b0, w_vol});
  assign w_prod_l = w_smp_l * w_gain;
  assign w_prod_r = w_smp_r * w_gain;
  assign w_term_l = w_mute ? '0 : {{(ACC_W-PROD_W){w_prod_l[PROD_W-1]}}, w_prod_l};
  assign w_term_r = w_mute ? '0 : {{(ACC_W-PROD_W){w_prod_r[PROD_W-1]}}, w_prod_r};

  // Divide by 8 with floor rounding, then saturate
  assign w_mix_l  = r_acc_l >>> 3;
  assign w_mix_r  = r_acc_r >>> 3;
  assign w_sat_l  = f_sat(w_mix_l);
  assign w_sat_r  = f_sat(w_mix_r);

  generate
    if (OUT_W > IN_W) begin : g_pad
      assign w_out_l = {w_sat_l, {(OUT_W-IN_W){1'b0}}};
      assign w_out_r = {w_sat_r, {(OUT_W-IN_W){1'b0}}};
    end else begin : g_nopad
      assign w_out_l = w_sat_l;
      assign w_out_r = w_sat_r;
    end
  endgenerate

  // Mix sequencer: snapshot, per-channel accumulate, saturate and publish; sticky overrun tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_snap_l  <= '0;
      r_snap_r  <= '0;
      r_snap_v  <= '0;
      r_snap_m  <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // A strobe arriving mid-mix is dropped; setting takes priority over clearing
      if (next_sample && r_busy) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (next_sample) begin
            r_snap_l <= ch_left;
            r_snap_r <= ch_right;
            r_snap_v <= ch_volume;
            r_snap_m <= ch_mute;
            r_idx    <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc_l <= r_acc_l + w_term_l;
          r_acc_r <= r_acc_r + w_term_r;
          if (r_idx == c_LAST_IDX) begin
            r_state <= S_SAT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_SAT: begin
          r_left  <= w_out_l;
          r_right <= w_out_r;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign left_out  = r_left;
  assign right_out = r_right;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_mixer
//  Description : Directed and randomized checks of audio_mixer against an
//                arithmetic reference model (NUM_CH=4, IN_W=16, OUT_W=24).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mixer;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 24;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   next_sample = 1'b0;
  logic                   overrun_clr = 1'b0;
  logic [NUM_CH*IN_W-1:0] ch_left = '0;
  logic [NUM_CH*IN_W-1:0] ch_right = '0;
  logic [NUM_CH*4-1:0]    ch_volume = '0;
  logic [NUM_CH-1:0]      ch_mute = '0;
  logic [OUT_W-1:0]       left_out;
  logic [OUT_W-1:0]       right_out;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  int n_vec = 0;
  int n_err = 0;

  int smpL [NUM_CH];
  int smpR [NUM_CH];
  int vol  [NUM_CH];
  bit mu   [NUM_CH];

  audio_mixer #(
    .NUM_CH (NUM_CH),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .ch_left     (ch_left),
    .ch_right    (ch_right),
    .ch_volume   (ch_volume),
    .ch_mute     (ch_mute),
    .overrun_clr (overrun_clr),
    .left_out    (left_out),
    .right_out   (right_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: gain vol/8, floor division, clamp to 16-bit, left-justify
  function automatic logic [23:0] model(input bit right);
    longint s;
    logic [15:0] q;
    s = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!mu[c]) s += longint'(right ? smpR[c] : smpL[c]) * longint'(vol[c]);
    end
    s = s >>> 3;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    q = s[15:0];
    return {q, 8'h00};
  endfunction

  task automatic clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      smpL[c] = 0; smpR[c] = 0; vol[c] = 0; mu[c] = 1'b1;
    end
  endtask

  task automatic set_ch(input int c, input int l, input int r, input int v, input bit m);
    smpL[c] = l; smpR[c] = r; vol[c] = v; mu[c] = m;
  endtask

  task automatic randomize_all();
    logic [15:0] t;
    for (int c = 0; c < NUM_CH; c++) begin
      t = 16'($urandom); smpL[c] = int'($signed(t));
      t = 16'($urandom); smpR[c] = int'($signed(t));
      vol[c] = int'($urandom_range(0, 15));
      mu[c]  = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drive_inputs();
    logic [31:0] tl, tr, tv;
    for (int c = 0; c < NUM_CH; c++) begin
      tl = smpL[c]; tr = smpR[c]; tv = vol[c];
      ch_left[c*16 +: 16]  = tl[15:0];
      ch_right[c*16 +: 16] = tr[15:0];
      ch_volume[c*4 +: 4]  = tv[3:0];
      ch_mute[c]           = mu[c];
    end
  endtask

  // Strobe is sampled at the posedge between the two negedges (E0)
  task automatic strobe();
    @(negedge clk); next_sample = 1'b1;
    @(negedge clk); next_sample = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (out_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_mix(input string tag, input logic [23:0] eL, input logic [23:0] eR);
    int n;
    drive_inputs();
    strobe();
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    wait_valid(0, n);
    check({tag, "_latency"}, n, 32'd5);
    check({tag, "_left"}, 32'(left_out), 32'(eL));
    check({tag, "_right"}, 32'(right_out), 32'(eR));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic [23:0] cap_l;
    logic [23:0] expL;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single channel, unity gain
    clear_all();
    set_ch(0, 32'h1234, -32'sh1234, 8, 1'b0);
    run_mix("unity", 24'h123400, 24'hEDCC00);

    // Positive and negative saturation
    clear_all();
    set_ch(0, 32'h7000, 0, 8, 1'b0);
    set_ch(1, 32'h7000, 0, 8, 1'b0);
    run_mix("sat_pos", 24'h7FFF00, 24'h000000);
    clear_all();
    set_ch(0, -28672, 0, 8, 1'b0);
    set_ch(1, -28672, 0, 8, 1'b0);
    run_mix("sat_neg", 24'h800000, 24'h000000);

    // Gain, zero volume, mute, floor rounding
    clear_all();
    set_ch(0, 32'h0100, 0, 15, 1'b0);
    run_mix("vol15", 24'h01E000, 24'h000000);
    set_ch(0, 32'h0100, 0, 0, 1'b0);
    run_mix("vol0", 24'h000000, 24'h000000);
    set_ch(0, 32'h0100, 0, 15, 1'b1);
    run_mix("muted", 24'h000000, 24'h000000);
    set_ch(0, -1, -1, 1, 1'b0);
    run_mix("floor", 24'hFFFF00, 24'hFFFF00);

    // Randomized mixes against the model
    for (int i = 0; i < 20; i++) begin
      randomize_all();
      run_mix($sformatf("rnd%0d", i), model(1'b0), model(1'b1));
    end

    // Dropped strobe while busy sets overrun and leaves the snapshot alone
    randomize_all();
    mu[0] = 1'b0; vol[0] = 9;
    expL = model(1'b0);
    drive_inputs();
    strobe();
    @(negedge clk);
    ch_left = {$urandom(), $urandom()};
    ch_volume = 16'($urandom);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    cnt = 0;
    cap_l = '0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        cnt++;
        cap_l = left_out;
      end
    end
    check("ovr_one_valid", cnt, 32'd1);
    check("ovr_snapshot", 32'(cap_l), 32'(expL));

    // Clear together with a dropped strobe: set wins; clear alone clears
    randomize_all();
    drive_inputs();
    strobe();
    next_sample = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    wait_valid(2, n);
    check("ovr_mix_lat", n, 32'd5);
    check("ovr_mix_left", 32'(left_out), 32'(model(1'b0)));
    check("ovr_mix_right", 32'(right_out), 32'(model(1'b1)));

    // Inputs scrambled after the strobe must not affect the result
    randomize_all();
    drive_inputs();
    strobe();
    repeat (4) begin
      ch_left   = {$urandom(), $urandom()};
      ch_right  = {$urandom(), $urandom()};
      ch_volume = 16'($urandom);
      ch_mute   = 4'($urandom);
      @(negedge clk);
    end
    wait_valid(4, n);
    check("snap_lat", n, 32'd5);
    check("snap_left", 32'(left_out), 32'(model(1'b0)));
    check("snap_right", 32'(right_out), 32'(model(1'b1)));

    // Reset mid-accumulation aborts the mix
    clear_all();
    set_ch(0, 32'h1234, -32'sh1234, 8, 1'b0);
    run_mix("pre_rst", 24'h123400, 24'hEDCC00);
    randomize_all();
    drive_inputs();
    strobe();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_left", 32'(left_out), 32'd0);
    check("arst_right", 32'(right_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt++;
    end
    check("arst_no_valid", cnt, 32'd0);
    check("arst_idle", 32'(busy), 32'd0);
    randomize_all();
    run_mix("post_rst", model(1'b0), model(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
